// File: rtl/hazard_issue_gate.sv
// Single-slot issue gate: holds one decoded instruction, stalls on pending-write hazards, tracks writes per register.
// Latency: accepted at edge N, offered in cycle N+1 at earliest; 1 instr/cycle sustained when hazard-free.
// Backpressure: in_ready = !hold_valid | out_fire (combinational through out_ready); forced low during flush.
module hazard_issue_gate #(
    parameter int NREGS     = 16,
    parameter int CNT_W     = 2,
    parameter int PAYLOAD_W = 64,
    localparam int IDX_W    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IDX_W-1:0]     in_src_a,
    input  logic                 in_src_a_en,
    input  logic [IDX_W-1:0]     in_src_b,
    input  logic                 in_src_b_en,
    input  logic [IDX_W-1:0]     in_dst,
    input  logic                 in_dst_en,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [NREGS-1:0]     out_req,
    output logic [NREGS-1:0]     out_prov,
    input  logic                 wb_valid,
    input  logic [IDX_W-1:0]     wb_dst,
    output logic [NREGS-1:0]     busy,
    output logic                 err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [IDX_W-1:0]     src_a;
        logic                 src_a_en;
        logic [IDX_W-1:0]     src_b;
        logic                 src_b_en;
        logic [IDX_W-1:0]     dst;
        logic                 dst_en;
        logic [PAYLOAD_W-1:0] payload;
    } slot_t;

    function automatic logic [NREGS-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    logic             hold_valid_q, hold_valid_d;
    slot_t            slot_q, slot_d;
    logic [CNT_W-1:0] pending_q [NREGS];
    logic [CNT_W-1:0] pending_d [NREGS];
    logic             err_underflow_q, err_underflow_d;

    logic             hazard;
    logic             out_fire;
    logic             in_fire;
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] dec_vec;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            busy[r] = (pending_q[r] != '0);
        end
    end

    // Hazard looks only at registered counters; a same-cycle writeback does not unblock.
    assign hazard = (slot_q.src_a_en && pending_q[slot_q.src_a] != '0)
                  | (slot_q.src_b_en && pending_q[slot_q.src_b] != '0)
                  | (slot_q.dst_en   && pending_q[slot_q.dst]   == CNT_MAX);

    assign out_valid = hold_valid_q && !hazard && !flush;
    assign out_fire  = out_valid && out_ready;
    assign in_ready  = !flush && (!hold_valid_q || out_fire);
    assign in_fire   = in_valid && in_ready;

    assign out_payload = slot_q.payload;
    assign out_req     = hold_valid_q ? ((slot_q.src_a_en ? onehot(slot_q.src_a) : '0)
                                       | (slot_q.src_b_en ? onehot(slot_q.src_b) : '0)) : '0;
    assign out_prov    = (hold_valid_q && slot_q.dst_en) ? onehot(slot_q.dst) : '0;
    assign err_underflow = err_underflow_q;

    assign inc_vec = (out_fire && slot_q.dst_en) ? onehot(slot_q.dst) : '0;
    assign dec_vec = wb_valid ? (onehot(wb_dst) & busy) : '0;

    always_comb begin
        hold_valid_d = hold_valid_q;
        slot_d       = slot_q;
        if (flush) begin
            hold_valid_d = 1'b0;
        end else if (in_fire) begin
            hold_valid_d    = 1'b1;
            slot_d.src_a    = in_src_a;
            slot_d.src_a_en = in_src_a_en;
            slot_d.src_b    = in_src_b;
            slot_d.src_b_en = in_src_b_en;
            slot_d.dst      = in_dst;
            slot_d.dst_en   = in_dst_en;
            slot_d.payload  = in_payload;
        end else if (out_fire) begin
            hold_valid_d = 1'b0;
        end
    end

    always_comb begin
        err_underflow_d = err_underflow_q;
        if (wb_valid && pending_q[wb_dst] == '0) begin
            err_underflow_d = 1'b1;
        end
        for (int r = 0; r < NREGS; r++) begin
            pending_d[r] = pending_q[r];
            if (flush) begin
                pending_d[r] = '0;
            end else if (inc_vec[r] && !dec_vec[r]) begin
                pending_d[r] = pending_q[r] + CNT_W'(1);
            end else if (dec_vec[r] && !inc_vec[r]) begin
                pending_d[r] = pending_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid_q    <= 1'b0;
            slot_q          <= '0;
            err_underflow_q <= 1'b0;
            for (int r = 0; r < NREGS; r++) begin
                pending_q[r] <= '0;
            end
        end else begin
            hold_valid_q    <= hold_valid_d;
            slot_q          <= slot_d;
            err_underflow_q <= err_underflow_d;
            for (int r = 0; r < NREGS; r++) begin
                pending_q[r] <= pending_d[r];
            end
        end
    end

endmodule

// File: tb/tb_hazard_issue_gate.sv
// Directed bench for hazard_issue_gate: hand-computed expectations checked with immediate assertions.
module tb_hazard_issue_gate;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_src_a;
    logic        in_src_a_en;
    logic [3:0]  in_src_b;
    logic        in_src_b_en;
    logic [3:0]  in_dst;
    logic        in_dst_en;
    logic [63:0] in_payload;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_payload;
    logic [15:0] out_req;
    logic [15:0] out_prov;
    logic        wb_valid;
    logic [3:0]  wb_dst;
    logic [15:0] busy;
    logic        err_underflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_issue_gate dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_src_a     (in_src_a),
        .in_src_a_en  (in_src_a_en),
        .in_src_b     (in_src_b),
        .in_src_b_en  (in_src_b_en),
        .in_dst       (in_dst),
        .in_dst_en    (in_dst_en),
        .in_payload   (in_payload),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_payload  (out_payload),
        .out_req      (out_req),
        .out_prov     (out_prov),
        .wb_valid     (wb_valid),
        .wb_dst       (wb_dst),
        .busy         (busy),
        .err_underflow(err_underflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks sample 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic [3:0] sa, input logic sa_en, input logic [3:0] sb,
                            input logic sb_en, input logic [3:0] d, input logic d_en,
                            input logic [63:0] pl);
        in_valid    = 1'b1;
        in_src_a    = sa;
        in_src_a_en = sa_en;
        in_src_b    = sb;
        in_src_b_en = sb_en;
        in_dst      = d;
        in_dst_en   = d_en;
        in_payload  = pl;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_src_a = '0; in_src_a_en = 1'b0; in_src_b = '0; in_src_b_en = 1'b0;
        in_dst = '0; in_dst_en = 1'b0; in_payload = '0;
        out_ready = 1'b0; wb_valid = 1'b0; wb_dst = '0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_req",   64'(out_req),   64'd0);
        chk("rst_out_prov",  64'(out_prov),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_err",       64'(err_underflow), 64'd0);
        reset = 1'b1;
        tick();

        // Basic issue: src_a=r1, dst=r2
        drive_in(4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 64'hA1A1_0000_0000_0001);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_req",   64'(out_req),   64'h0002);
        chk("t1_out_prov",  64'(out_prov),  64'h0004);
        chk("t1_payload",   out_payload,    64'hA1A1_0000_0000_0001);
        tick();
        #2;
        chk("t1_busy",      64'(busy),      64'h0004);
        chk("t1_idle",      64'(out_valid), 64'd0);
        chk("t1_in_ready",  64'(in_ready),  64'd1);
        wb_valid = 1'b1; wb_dst = 4'd2;
        tick();
        wb_valid = 1'b0;
        #2;
        chk("t1_busy_clr",  64'(busy),      64'd0);

        // RAW stall on r5 released by writeback
        drive_in(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 64'h55);
        tick();
        drive_in(4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 64'h56);
        #2;
        chk("t2_first_valid", 64'(out_valid), 64'd1);
        tick();
        in_valid = 1'b0;
        #2;
        chk("t2_stall_valid", 64'(out_valid), 64'd0);
        chk("t2_stall_req",   64'(out_req),   64'h0020);
        chk("t2_stall_rdy",   64'(in_ready),  64'd0);
        chk("t2_busy",        64'(busy),      64'h0020);
        tick();
        wb_valid = 1'b1; wb_dst = 4'd5;
        #2;
        chk("t2_no_bypass",   64'(out_valid), 64'd0);
        tick();
        wb_valid = 1'b0;
        #2;
        chk("t2_released",    64'(out_valid), 64'd1);
        chk("t2_busy_clr",    64'(busy),      64'd0);
        chk("t2_payload",     out_payload,    64'h56);
        tick();
        #2;
        chk("t2_drained",     64'(in_ready),  64'd1);

        // Saturation: three writes to r7 outstanding, fourth must stall
        drive_in(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 64'h70);
        tick(); tick(); tick(); tick();
        in_valid = 1'b0;
        #2;
        chk("t3_sat_stall",  64'(out_valid), 64'd0);
        chk("t3_sat_prov",   64'(out_prov),  64'h0080);
        chk("t3_sat_rdy",    64'(in_ready),  64'd0);
        wb_valid = 1'b1; wb_dst = 4'd7;
        tick();
        wb_valid = 1'b0;
        #2;
        chk("t3_sat_issue",  64'(out_valid), 64'd1);
        tick();
        #2;
        chk("t3_after_fire", 64'(out_valid), 64'd0);
        wb_valid = 1'b1; wb_dst = 4'd7;
        tick(); tick();
        #2;
        chk("t3_two_left_1", 64'(busy),      64'h0080);
        tick();
        wb_valid = 1'b0;
        #2;
        chk("t3_count3",     64'(busy),      64'd0);
        chk("t3_no_err",     64'(err_underflow), 64'd0);

        // Simultaneous issue and writeback on r4 nets to no change
        drive_in(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 64'h40);
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        chk("t4_busy_a",     64'(busy),      64'h0010);
        drive_in(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 64'h41);
        tick();
        in_valid = 1'b0;
        #2;
        chk("t4_second_vld", 64'(out_valid), 64'd1);
        wb_valid = 1'b1; wb_dst = 4'd4;
        tick();
        #2;
        chk("t4_net_zero",   64'(busy),      64'h0010);
        tick();
        wb_valid = 1'b0;
        #2;
        chk("t4_cnt_was_1",  64'(busy),      64'd0);
        chk("t4_no_err",     64'(err_underflow), 64'd0);

        // Underflow on r9 is sticky
        wb_valid = 1'b1; wb_dst = 4'd9;
        tick();
        wb_valid = 1'b0;
        #2;
        chk("t5_err_set",    64'(err_underflow), 64'd1);
        chk("t5_busy",       64'(busy),      64'd0);
        tick();
        #2;
        chk("t5_err_sticky", 64'(err_underflow), 64'd1);

        // Flush with a stalled slot and pending r1, r2
        drive_in(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 64'h11);
        tick();
        drive_in(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 64'h12);
        tick();
        drive_in(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 64'h13);
        tick();
        in_valid = 1'b0;
        #2;
        chk("t6_busy",       64'(busy),      64'h0006);
        chk("t6_stalled",    64'(out_valid), 64'd0);
        flush = 1'b1;
        drive_in(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 64'h33);
        #2;
        chk("t6_flush_rdy",  64'(in_ready),  64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #2;
        chk("t6_f_valid",    64'(out_valid), 64'd0);
        chk("t6_f_busy",     64'(busy),      64'd0);
        chk("t6_f_rdy",      64'(in_ready),  64'd1);
        chk("t6_f_req",      64'(out_req),   64'd0);
        chk("t6_f_prov",     64'(out_prov),  64'd0);
        chk("t6_f_err_keep", 64'(err_underflow), 64'd1);

        // Asynchronous reset between edges
        drive_in(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 64'h66);
        tick();
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        chk("t7_busy",       64'(busy),      64'h0040);
        chk("t7_prov",       64'(out_prov),  64'h0040);
        reset = 1'b0;
        #1;
        chk("t7_ar_busy",    64'(busy),      64'd0);
        chk("t7_ar_prov",    64'(out_prov),  64'd0);
        chk("t7_ar_rdy",     64'(in_ready),  64'd1);
        chk("t7_ar_err",     64'(err_underflow), 64'd0);
        chk("t7_ar_valid",   64'(out_valid), 64'd0);
        reset = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_issue_gate.md
Name: hazard_issue_gate

Overview:
- Producer end of the req/prov hazard interface. Sits between decode and operand fetch.
- Accepts decoded instructions (source/destination register numbers plus payload) and holds each one in a single-entry slot.
- Emits the 16-bit read-mask (req) and write-mask (prov) for the held instruction.
- Tracks in-flight writes per register with saturating counters, released by writeback. Issues an instruction only when none of its sources have a pending write.

Parameters:
NREGS, 16, number of architectural registers; equals mask width
CNT_W, 2, width of per-register pending-write counter; max outstanding writes per register = 2^CNT_W-1
PAYLOAD_W, 64, width of opaque instruction payload carried through

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous squash of held slot and all pending counters
in_valid  input  1  decoded instruction present
in_ready  output  1  slot can accept this cycle
in_src_a  input  4  source A register number
in_src_a_en  input  1  source A used
in_src_b  input  4  source B register number
in_src_b_en  input  1  source B used
in_dst  input  4  destination register number
in_dst_en  input  1  destination written
in_payload  input  PAYLOAD_W  opaque instruction bits
out_valid  output  1  held instruction hazard-free, offered downstream
out_ready  input  1  downstream accepts
out_payload  output  PAYLOAD_W  held payload
out_req  output  NREGS  one-hot OR of enabled sources of held instruction
out_prov  output  NREGS  one-hot of enabled destination of held instruction
wb_valid  input  1  writeback retiring a register write
wb_dst  input  4  register retired
busy  output  NREGS  bit i = pending[i] != 0
err_underflow  output  1  sticky: writeback to register with zero pending count

Behaviour:
- Reset (reset=0, async): hold_valid=0; all pending counters=0; err_underflow=0. Outputs follow: out_valid=0, out_req=0, out_prov=0, busy=0, in_ready=1. out_payload is don't-care.
- Held slot: hold_valid plus registered src/dst/enable/payload fields.
- Definitions:
  - out_fire = out_valid & out_ready
  - in_fire = in_valid & in_ready
  - in_ready = !hold_valid | out_fire (combinational through out_ready)
- hazard = (src_a_en & pending[src_a]!=0) | (src_b_en & pending[src_b]!=0) | (dst_en & pending[dst]==2^CNT_W-1).
  - Computed from registered counters only. There is no same-cycle writeback bypass.
- out_valid = hold_valid & !hazard & !flush.
- out_req and out_prov are driven whenever hold_valid=1, even while stalled. Both are 0 when hold_valid=0.
- Slot update on a clock edge with no flush:
  - in_fire: slot loads the input fields.
  - else if out_fire: hold_valid=0.
  - else: slot holds.
- Latency: instruction accepted at edge N is offered (out_valid=1) in cycle N+1 at earliest. Back-to-back issue sustains 1 instruction/cycle when hazard-free.
- Counter update per register r, applied each edge:
  - inc = out_fire & dst_en & dst==r
  - dec = wb_valid & wb_dst==r & pending[r]!=0
  - pending[r] += inc - dec. Simultaneous inc and dec nets to no change.
- Writeback to r with pending[r]==0: counter unchanged, err_underflow set (sticky until reset).
- Increment at max count cannot occur, because the dst-saturation hazard blocks issue.
- Self-dependency (src==dst, e.g. r3=r3+1) checks pending[src] before issue. It increments pending[dst] at issue.
- Writeback retiring the last pending write at edge N: a dependent held instruction sees out_valid=1 in cycle N+1.
- flush=1 at an edge: hold_valid=0, all counters=0, in_fire suppressed (in_ready forced 0 during flush), out_valid forced 0. err_underflow is preserved.
- Reset asserted mid-operation: the slot and counters clear immediately, with no reliance on clk.

Test Plan:
- Reset release, in_valid=1 src_a=r1 dst=r2, out_ready=1 -> cycle+1 out_valid=1, out_req=0x0002, out_prov=0x0004; next edge busy=0x0004.
- Issue dst=r5, then held src_a=r5 with no writeback -> out_valid=0 with out_req=0x0020 held and in_ready=0. wb_valid wb_dst=5 at edge N -> out_valid=1 in cycle N+1, busy=0.
- Three issues dst=r7 (CNT_W=2), fourth held dst=r7 -> fourth stalled. One wb to r7 -> fourth issues the following cycle; pending[7] returns to 3.
- Same edge: out_fire dst=r4 and wb_valid wb_dst=4 with pending[4]=1 -> pending[4] stays 1, busy[4]=1.
- wb_valid wb_dst=9 with pending[9]=0 -> err_underflow=1 and stays 1; flush does not clear it; reset=0 clears it.
- Stalled slot plus pending on r1,r2, assert flush one cycle -> next cycle hold_valid=0, busy=0, out_valid=0, in_ready=1. Also pulse reset=0 between clock edges -> outputs clear asynchronously.
